// File: rtl/mem_access_pkg.sv
// +---------------------------------------------------------------------------+
// | mem_access_pkg: shared state encoding, request source type and widths.    |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

package mem_access_pkg;

  localparam int LAT_W      = 4;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  typedef enum logic {
    SRC_IF = 1'b0,
    SRC_D  = 1'b1
  } src_e;

endpackage

`default_nettype wire

// File: rtl/mem_wait_timer.sv
// +---------------------------------------------------------------------------+
// | mem_wait_timer: loadable down-counter, 'last' high when count is zero.    |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

module mem_wait_timer
  import mem_access_pkg::*;
#(
  parameter int CNT_W = LAT_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             last
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign last = (cnt == '0);

endmodule

`default_nettype wire

// File: rtl/mem_access_ctrl.sv
// +---------------------------------------------------------------------------+
// | mem_access_ctrl: fetch/load/store sequencer for the single-port Memory.   |
// | Optional range check enabled by macro ADDR_CHECK_EN.        Rev 1.0       |
// +---------------------------------------------------------------------------+
`default_nettype none

module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MEM_LAT   = 0,
  parameter int MEM_DEPTH = 513
) (
  input  logic              Clk,
  input  logic              Resetn,
  input  logic              IfReq,
  input  logic [ADDR_W-1:0] IfAddr,
  output logic              IfAck,
  output logic [DATA_W-1:0] Instr,
  input  logic              DReq,
  input  logic              DWrite,
  input  logic [ADDR_W-1:0] DAddr,
  input  logic [DATA_W-1:0] DWData,
  output logic              DAck,
  output logic [DATA_W-1:0] DRData,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWData,
  output logic              MemWE,
  input  logic [DATA_W-1:0] MemRData,
  output logic              Busy,
  output logic              AddrErr
);

  if (MEM_LAT < 0 || MEM_LAT > 15) begin : g_lat_check
    $error("mem_access_ctrl: MEM_LAT must be within 0..15");
  end

  if (MEM_DEPTH < 1) begin : g_depth_check
    $error("mem_access_ctrl: MEM_DEPTH must be positive");
  end

  logic [1:0]        state;
  src_e              src;
  logic              wr;
  logic              cur_err;
  logic              accept;
  logic              last;
  logic              oob;
  logic [ADDR_W-1:0] sel_addr;

  // Data side wins arbitration; the fetch simply stays pending.
  assign accept   = (state == ST_IDLE) && (DReq || IfReq);
  assign sel_addr = DReq ? DAddr : IfAddr;

`ifdef ADDR_CHECK_EN
  assign oob = (sel_addr >= ADDR_W'(MEM_DEPTH));
`else
  assign oob = 1'b0;
`endif

  mem_wait_timer #(
    .CNT_W(LAT_W)
  ) u_timer (
    .clk     (Clk),
    .resetn  (Resetn),
    .load    (accept),
    .load_val(LAT_W'(MEM_LAT)),
    .en      (state == ST_ACCESS),
    .last    (last)
  );

  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      state    <= ST_IDLE;
      src      <= SRC_IF;
      wr       <= 1'b0;
      cur_err  <= 1'b0;
      IfAck    <= 1'b0;
      DAck     <= 1'b0;
      Instr    <= '0;
      DRData   <= '0;
      MemAddr  <= '0;
      MemWData <= '0;
    end else begin
      IfAck <= 1'b0;
      DAck  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state    <= ST_ACCESS;
            src      <= DReq ? SRC_D : SRC_IF;
            wr       <= DReq && DWrite;
            cur_err  <= oob;
            MemAddr  <= sel_addr;
            MemWData <= DWData;
          end
        end
        ST_ACCESS: begin
          if (last) begin
            state <= ST_RESP;
            if (src == SRC_IF) begin
              Instr <= cur_err ? '0 : MemRData;
              IfAck <= 1'b1;
            end else begin
              DAck <= 1'b1;
              if (!wr) begin
                DRData <= cur_err ? '0 : MemRData;
              end
            end
          end
        end
        ST_RESP:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

`ifdef ADDR_CHECK_EN
  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      AddrErr <= 1'b0;
    end else if (accept && oob) begin
      AddrErr <= 1'b1;
    end
  end
`else
  assign AddrErr = 1'b0;
`endif

  // Gated by Resetn so a reset landing on the write edge never commits it.
  assign MemWE = Resetn && (state == ST_ACCESS) && last && wr && !cur_err;
  assign Busy  = (state == ST_ACCESS) || (state == ST_RESP);

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// +---------------------------------------------------------------------------+
// | tb_mem_access_ctrl: directed plus random transactions vs. a memory model. |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_mem_access_ctrl;

  localparam int LAT   = 3;
  localparam int DEPTH = 513;

  logic        Clk = 1'b0;
  logic        Resetn;
  logic        IfReq, DReq, DWrite;
  logic [31:0] IfAddr, DAddr, DWData;
  logic        IfAck, DAck, MemWE, Busy, AddrErr;
  logic [31:0] Instr, DRData, MemAddr, MemWData, MemRData;

  logic [31:0] mem     [0:DEPTH-1];
  logic [31:0] ref_mem [0:DEPTH-1];
  logic        init_req;

  int          vectors    = 0;
  int          miscompares = 0;
  logic [31:0] exp_instr  = '0;
  logic [31:0] exp_dr     = '0;
  logic        exp_err    = 1'b0;

  always #5 Clk = ~Clk;

  mem_access_ctrl #(
    .ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .MEM_DEPTH(DEPTH)
  ) dut (
    .Clk(Clk), .Resetn(Resetn),
    .IfReq(IfReq), .IfAddr(IfAddr), .IfAck(IfAck), .Instr(Instr),
    .DReq(DReq), .DWrite(DWrite), .DAddr(DAddr), .DWData(DWData),
    .DAck(DAck), .DRData(DRData),
    .MemAddr(MemAddr), .MemWData(MemWData), .MemWE(MemWE), .MemRData(MemRData),
    .Busy(Busy), .AddrErr(AddrErr)
  );

  // Single-port Memory: combinational read, write on the rising edge.
  assign MemRData = (MemAddr < DEPTH) ? mem[MemAddr[9:0]] : 32'h0;

  always @(posedge Clk) begin
    if (init_req) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= ref_mem[i];
    end else if (MemWE && (MemAddr < DEPTH)) begin
      mem[MemAddr[9:0]] <= MemWData;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_check();
    @(negedge Clk);
    chk("ack_one_cycle", {30'b0, IfAck, DAck}, 32'h0);
    chk("idle_busy", {31'b0, Busy}, 32'h0);
  endtask

  // kind: 0 fetch, 1 load, 2 store
  task automatic do_txn(input int kind, input logic [31:0] addr, input logic [31:0] wd);
    int   cyc, busy_n, we_n;
    logic acked, if_seen, d_seen, oob;
    oob = (addr >= DEPTH);
    if (kind == 0) begin
      IfReq = 1'b1; IfAddr = addr;
    end else begin
      DReq = 1'b1; DWrite = (kind == 2); DAddr = addr; DWData = wd;
    end
    cyc = 0; busy_n = 0; we_n = 0; acked = 1'b0; if_seen = 1'b0; d_seen = 1'b0;
    while (!acked && cyc < 40) begin
      @(negedge Clk);
      cyc++;
      if (Busy) busy_n++;
      if (MemWE) we_n++;
      if (IfAck || DAck) begin
        acked = 1'b1; if_seen = IfAck; d_seen = DAck;
      end
    end
    IfReq = 1'b0; DReq = 1'b0;
    chk("ack_seen", {31'b0, acked}, 32'h1);
    if (oob) exp_err = 1'b1;
    case (kind)
      0: exp_instr = oob ? 32'h0 : ref_mem[addr[9:0]];
      1: exp_dr    = oob ? 32'h0 : ref_mem[addr[9:0]];
      default: if (!oob) ref_mem[addr[9:0]] = wd;
    endcase
    chk("latency", cyc, LAT + 2);
    chk("busy_cycles", busy_n, LAT + 2);
    chk("we_cycles", we_n, (kind == 2 && !oob) ? 1 : 0);
    chk("if_ack", {31'b0, if_seen}, {31'b0, kind == 0});
    chk("d_ack", {31'b0, d_seen}, {31'b0, kind != 0});
    chk("instr", Instr, exp_instr);
    chk("drdata", DRData, exp_dr);
    chk("addr_err", {31'b0, AddrErr}, {31'b0, exp_err});
    if (kind == 2 && !oob) chk("mem_word", mem[addr[9:0]], ref_mem[addr[9:0]]);
    idle_check();
  endtask

  // Load and fetch raised together: the load must win.
  task automatic do_pair(input logic [31:0] a_d, input logic [31:0] a_i);
    int d_cyc, i_cyc, cyc;
    d_cyc = 0; i_cyc = 0; cyc = 0;
    DReq = 1'b1; DWrite = 1'b0; DAddr = a_d;
    IfReq = 1'b1; IfAddr = a_i;
    while ((d_cyc == 0 || i_cyc == 0) && cyc < 60) begin
      @(negedge Clk);
      cyc++;
      if (DAck && d_cyc == 0) begin d_cyc = cyc; DReq = 1'b0; end
      if (IfAck && i_cyc == 0) begin i_cyc = cyc; IfReq = 1'b0; end
    end
    DReq = 1'b0; IfReq = 1'b0;
    exp_dr    = ref_mem[a_d[9:0]];
    exp_instr = ref_mem[a_i[9:0]];
    chk("pair_dack_cycle", d_cyc, LAT + 2);
    chk("pair_ifack_cycle", i_cyc, 2 * LAT + 5);
    chk("pair_drdata", DRData, exp_dr);
    chk("pair_instr", Instr, exp_instr);
    idle_check();
  endtask

  initial begin
    int          we_n;
    int          kind;
    logic [31:0] a, w, old6;

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = $urandom;
    ref_mem[128] = 32'h8c030000;
    ref_mem[1]   = 32'h1;
    ref_mem[0]   = 32'h8;

    Resetn = 1'b0; init_req = 1'b1;
    IfReq = 1'b0; DReq = 1'b0; DWrite = 1'b0;
    IfAddr = '0; DAddr = '0; DWData = '0;
    repeat (3) @(negedge Clk);
    chk("rst_acks", {30'b0, IfAck, DAck}, 32'h0);
    chk("rst_busy_we_err", {29'b0, Busy, MemWE, AddrErr}, 32'h0);
    chk("rst_instr", Instr, 32'h0);
    chk("rst_drdata", DRData, 32'h0);
    chk("rst_memaddr", MemAddr, 32'h0);
    chk("rst_memwdata", MemWData, 32'h0);
    init_req = 1'b0; Resetn = 1'b1;
    @(negedge Clk);

    do_txn(0, 32'd128, 32'h0);
    do_txn(2, 32'd6, 32'hDEADBEEF);
    do_txn(1, 32'd6, 32'h0);
    chk("load_after_store", DRData, 32'hDEADBEEF);
    do_pair(32'd1, 32'd128);
    do_txn(1, 32'd0, 32'h0);

    // Reset lands on the last ACCESS cycle of a store.
    old6 = ref_mem[6];
    DReq = 1'b1; DWrite = 1'b1; DAddr = 32'd6; DWData = 32'h12345678;
    we_n = 0;
    repeat (LAT) begin
      @(negedge Clk);
      if (MemWE) we_n++;
    end
    @(negedge Clk);
    Resetn = 1'b0; DReq = 1'b0;
    #1;
    chk("rst_gates_we", {31'b0, MemWE}, 32'h0);
    chk("rst_early_we", we_n, 0);
    @(negedge Clk);
    chk("rst_mid_acks", {30'b0, IfAck, DAck}, 32'h0);
    chk("rst_mid_busy", {31'b0, Busy}, 32'h0);
    chk("rst_mid_instr", Instr, 32'h0);
    chk("rst_mid_drdata", DRData, 32'h0);
    chk("rst_mid_mem", mem[6], old6);
    Resetn = 1'b1;
    exp_instr = '0; exp_dr = '0; exp_err = 1'b0;
    @(negedge Clk);
    chk("rst_mid_no_ack", {30'b0, IfAck, DAck}, 32'h0);

`ifdef ADDR_CHECK_EN
    do_txn(2, 32'd600, 32'hCAFEF00D);
`endif

    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 2);
      a    = $urandom_range(0, DEPTH - 1);
      w    = $urandom;
`ifdef ADDR_CHECK_EN
      if ($urandom_range(0, 7) == 0) a = 32'd513 + $urandom_range(0, 1000);
`endif
      do_txn(kind, a, w);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
